control_unit_top: RTL and testbench

RV32I decode-and-execute block: decodes a 32-bit instruction into single-cycle datapath control signals and executes the selected ALU operation on two 32-bit operands. It sits between instruction fetch and register-file writeback in the CS61C-style datapath. Control outputs are combinational. ALU result and flags are registered.

---
 rtl/control_unit_top.sv | 210 +++++++++++++++++++++
 tb/tb_control_unit_top.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_top.sv
// RV32I decode-and-execute: combinational control decode and a registered ALU.
// Control outputs follow instr directly; result, zero and Sign lag by one edge.
module control_unit_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [3:0]  ALUControl,
    output logic [2:0]  ImmSel,
    output logic [1:0]  WBSel,
    output logic        BrUn,
    output logic        ASel,
    output logic        BSel,
    output logic        MemRW,
    output logic        RegWEn,
    output logic        PCSel,
    output logic [31:0] result,
    output logic        zero,
    output logic        Sign
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_PASS = 4'b1010;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7;
    logic        unused_instr;

    logic [3:0]  arith_op;
    logic [3:0]  alu_ctl_d;
    logic [2:0]  imm_sel_d;
    logic [1:0]  wb_sel_d;
    logic        br_un_d;
    logic        a_sel_d;
    logic        b_sel_d;
    logic        mem_rw_d;
    logic        reg_wen_d;
    logic        pc_sel_d;

    logic [31:0] alu_y;
    logic [31:0] result_q;
    logic        zero_q;
    logic        sign_q;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign f7           = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // Shared R/I-ALU op; SUB only exists for R-type, SRA for both
    always_comb begin
        arith_op = ALU_ADD;
        unique case (funct3)
            3'b000:  arith_op = (f7 && opcode == OP_R) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin
        alu_ctl_d = ALU_ADD;
        imm_sel_d = IMM_I;
        wb_sel_d  = WB_MEM;
        br_un_d   = 1'b0;
        a_sel_d   = 1'b0;
        b_sel_d   = 1'b0;
        mem_rw_d  = 1'b0;
        reg_wen_d = 1'b0;
        pc_sel_d  = 1'b0;
        unique case (1'b1)
            (opcode == OP_R): begin
                alu_ctl_d = arith_op;
                wb_sel_d  = WB_ALU;
                reg_wen_d = 1'b1;
            end
            (opcode == OP_I): begin
                alu_ctl_d = arith_op;
                b_sel_d   = 1'b1;
                wb_sel_d  = WB_ALU;
                reg_wen_d = 1'b1;
            end
            (opcode == OP_LOAD): begin
                b_sel_d   = 1'b1;
                reg_wen_d = 1'b1;
            end
            (opcode == OP_STORE): begin
                b_sel_d   = 1'b1;
                imm_sel_d = IMM_S;
                mem_rw_d  = 1'b1;
            end
            (opcode == OP_BR): begin
                a_sel_d   = 1'b1;
                b_sel_d   = 1'b1;
                imm_sel_d = IMM_B;
                br_un_d   = funct3[1];
            end
            (opcode == OP_JAL): begin
                a_sel_d   = 1'b1;
                b_sel_d   = 1'b1;
                imm_sel_d = IMM_J;
                wb_sel_d  = WB_PC4;
                reg_wen_d = 1'b1;
                pc_sel_d  = 1'b1;
            end
            (opcode == OP_JALR): begin
                b_sel_d   = 1'b1;
                wb_sel_d  = WB_PC4;
                reg_wen_d = 1'b1;
                pc_sel_d  = 1'b1;
            end
            (opcode == OP_LUI): begin
                alu_ctl_d = ALU_PASS;
                b_sel_d   = 1'b1;
                imm_sel_d = IMM_U;
                wb_sel_d  = WB_ALU;
                reg_wen_d = 1'b1;
            end
            (opcode == OP_AUIPC): begin
                a_sel_d   = 1'b1;
                b_sel_d   = 1'b1;
                imm_sel_d = IMM_U;
                wb_sel_d  = WB_ALU;
                reg_wen_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Side-effecting strobes are held off while reset is asserted
    assign ALUControl = alu_ctl_d;
    assign ImmSel     = imm_sel_d;
    assign WBSel      = wb_sel_d;
    assign BrUn       = br_un_d;
    assign ASel       = a_sel_d;
    assign BSel       = b_sel_d;
    assign MemRW      = mem_rw_d & rst_n;
    assign RegWEn     = reg_wen_d & rst_n;
    assign PCSel      = pc_sel_d & rst_n;

    always_comb begin
        alu_y = '0;
        unique case (alu_ctl_d)
            ALU_ADD:  alu_y = a + b;
            ALU_SUB:  alu_y = a - b;
            ALU_AND:  alu_y = a & b;
            ALU_OR:   alu_y = a | b;
            ALU_XOR:  alu_y = a ^ b;
            ALU_SLL:  alu_y = a << b[4:0];
            ALU_SRL:  alu_y = a >> b[4:0];
            ALU_SRA:  alu_y = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  alu_y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: alu_y = {31'd0, a < b};
            ALU_PASS: alu_y = b;
            default:  alu_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            result_q <= alu_y;
            zero_q   <= (alu_y == 32'd0);
            sign_q   <= alu_y[31];
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign Sign   = sign_q;

endmodule

// File: tb/tb_control_unit_top.sv
// Scoreboard bench for control_unit_top: decode checked same cycle,
// ALU result/flags checked against queued expectations one edge later.
module tb_control_unit_top;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ALUControl;
    logic [2:0]  ImmSel;
    logic [1:0]  WBSel;
    logic        BrUn;
    logic        ASel;
    logic        BSel;
    logic        MemRW;
    logic        RegWEn;
    logic        PCSel;
    logic [31:0] result;
    logic        zero;
    logic        Sign;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        s;
    } exp_t;

    // instr, a, b, control {alu,imm,wb,BrUn,ASel,BSel,MemRW,RegWEn,PCSel}, result
    typedef struct packed {
        logic [31:0] i;
        logic [31:0] a;
        logic [31:0] b;
        logic [14:0] c;
        logic [31:0] r;
    } vec_t;

    exp_t sb[$];

    control_unit_top dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .ImmSel     (ImmSel),
        .WBSel      (WBSel),
        .BrUn       (BrUn),
        .ASel       (ASel),
        .BSel       (BSel),
        .MemRW      (MemRW),
        .RegWEn     (RegWEn),
        .PCSel      (PCSel),
        .result     (result),
        .zero       (zero),
        .Sign       (Sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mk(input logic [6:0] op,
                                       input logic [2:0] f3,
                                       input logic f7b);
        return {1'b0, f7b, 5'd0, 5'd3, 5'd2, f3, 5'd1, op};
    endfunction

    function automatic logic [14:0] ctl_now();
        return {ALUControl, ImmSel, WBSel, BrUn, ASel, BSel, MemRW, RegWEn, PCSel};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] er);
        exp_t e;
        instr = ins;
        a     = ia;
        b     = ib;
        e.r   = er;
        e.z   = (er == 32'd0);
        e.s   = er[31];
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr = 32'h003100B3;
        a     = 32'd10;
        b     = 32'd20;
        #1;
        checks++;
        if (ctl_now() !== {4'h0, 3'b000, 2'b01, 6'b000000}) begin
            errors++;
            $display("FAIL rst_ctl_add: got %h want %h", ctl_now(),
                     {4'h0, 3'b000, 2'b01, 6'b000000});
        end
        instr = mk(7'b0100011, 3'b010, 1'b0);
        #1;
        checks++;
        if (ctl_now() !== {4'h0, 3'b001, 2'b00, 6'b001000}) begin
            errors++;
            $display("FAIL rst_ctl_store: got %h want %h", ctl_now(),
                     {4'h0, 3'b001, 2'b00, 6'b001000});
        end
        instr = mk(7'b1101111, 3'b000, 1'b0);
        #1;
        checks++;
        if (ctl_now() !== {4'h0, 3'b100, 2'b10, 6'b011000}) begin
            errors++;
            $display("FAIL rst_ctl_jal: got %h want %h", ctl_now(),
                     {4'h0, 3'b100, 2'b10, 6'b011000});
        end
        instr = 32'h003100B3;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({result, zero, Sign} !== {32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_regs: got r=%h z=%b s=%b want 0/0/0",
                     result, zero, Sign);
        end
        rst_n = 1'b1;
        drive(32'h003100B3, 32'd10, 32'd20, 32'd30);
        #1;
        checks++;
        if (ctl_now() !== {4'h0, 3'b000, 2'b01, 6'b000010}) begin
            errors++;
            $display("FAIL add_ctl: got %h want %h", ctl_now(),
                     {4'h0, 3'b000, 2'b01, 6'b000010});
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL rst_release: scoreboard empty");
        end else begin
            exp_t e = sb.pop_front();
            if ({result, zero, Sign} !== {e.r, e.z, e.s}) begin
                errors++;
                $display("FAIL rst_release: got r=%h z=%b s=%b want r=%h z=%b s=%b",
                         result, zero, Sign, e.r, e.z, e.s);
            end
        end
    endtask

    task automatic test_alu();
        vec_t v[$];
        v.push_back({32'h402180B3, 32'd20, 32'd10, {4'h1, 3'b000, 2'b01, 6'b000010}, 32'd10});
        v.push_back({32'h402180B3, 32'd7, 32'd7, {4'h1, 3'b000, 2'b01, 6'b000010}, 32'd0});
        v.push_back({mk(7'b0110011, 3'b010, 1'b0), 32'hFFFFFFFF, 32'd5,
                     {4'h8, 3'b000, 2'b01, 6'b000010}, 32'd1});
        v.push_back({mk(7'b0110011, 3'b011, 1'b0), 32'hFFFFFFFF, 32'd1,
                     {4'h9, 3'b000, 2'b01, 6'b000010}, 32'd0});
        v.push_back({mk(7'b0110011, 3'b111, 1'b0), 32'hF0F0F0F0, 32'h0F0F0F0F,
                     {4'h2, 3'b000, 2'b01, 6'b000010}, 32'd0});
        v.push_back({mk(7'b0110011, 3'b110, 1'b0), 32'hF0000000, 32'h0F000000,
                     {4'h3, 3'b000, 2'b01, 6'b000010}, 32'hFF000000});
        v.push_back({mk(7'b0110011, 3'b100, 1'b0), 32'hAAAAAAAA, 32'h55555555,
                     {4'h4, 3'b000, 2'b01, 6'b000010}, 32'hFFFFFFFF});
        v.push_back({mk(7'b0110011, 3'b001, 1'b0), 32'h00000003, 32'h00000024,
                     {4'h5, 3'b000, 2'b01, 6'b000010}, 32'h00000030});
        v.push_back({mk(7'b0110011, 3'b101, 1'b0), 32'h80000000, 32'd2,
                     {4'h6, 3'b000, 2'b01, 6'b000010}, 32'h20000000});
        v.push_back({mk(7'b0110011, 3'b101, 1'b1), 32'h80000000, 32'd2,
                     {4'h7, 3'b000, 2'b01, 6'b000010}, 32'hE0000000});
        v.push_back({32'h003100B3, 32'hFFFFFFFF, 32'd1,
                     {4'h0, 3'b000, 2'b01, 6'b000010}, 32'd0});
        foreach (v[k]) begin
            drive(v[k].i, v[k].a, v[k].b, v[k].r);
            #1;
            checks++;
            if (ctl_now() !== v[k].c) begin
                errors++;
                $display("FAIL alu_ctl[%0d]: got %h want %h", k, ctl_now(), v[k].c);
            end
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL alu_res[%0d]: scoreboard empty", k);
            end else begin
                exp_t e = sb.pop_front();
                if ({result, zero, Sign} !== {e.r, e.z, e.s}) begin
                    errors++;
                    $display("FAIL alu_res[%0d]: got r=%h z=%b s=%b want r=%h z=%b s=%b",
                             k, result, zero, Sign, e.r, e.z, e.s);
                end
            end
        end
    endtask

    task automatic test_decode();
        vec_t v[$];
        v.push_back({mk(7'b0100011, 3'b010, 1'b0), 32'd100, 32'd8,
                     {4'h0, 3'b001, 2'b00, 6'b001100}, 32'd108});
        v.push_back({mk(7'b0000011, 3'b010, 1'b0), 32'd100, 32'd4,
                     {4'h0, 3'b000, 2'b00, 6'b001010}, 32'd104});
        v.push_back({mk(7'b1100011, 3'b110, 1'b0), 32'h1000, 32'h10,
                     {4'h0, 3'b010, 2'b00, 6'b111000}, 32'h1010});
        v.push_back({mk(7'b1100011, 3'b100, 1'b0), 32'h1000, 32'h20,
                     {4'h0, 3'b010, 2'b00, 6'b011000}, 32'h1020});
        v.push_back({mk(7'b1101111, 3'b000, 1'b0), 32'h2000, 32'h100,
                     {4'h0, 3'b100, 2'b10, 6'b011011}, 32'h2100});
        v.push_back({mk(7'b1100111, 3'b000, 1'b0), 32'h3000, 32'h8,
                     {4'h0, 3'b000, 2'b10, 6'b001011}, 32'h3008});
        v.push_back({mk(7'b0110111, 3'b000, 1'b0), 32'hDEADBEEF, 32'h12345000,
                     {4'hA, 3'b011, 2'b01, 6'b001010}, 32'h12345000});
        v.push_back({mk(7'b0010111, 3'b000, 1'b0), 32'h400, 32'h1000,
                     {4'h0, 3'b011, 2'b01, 6'b011010}, 32'h1400});
        v.push_back({mk(7'b0010011, 3'b000, 1'b1), 32'd50, 32'd8,
                     {4'h0, 3'b000, 2'b01, 6'b001010}, 32'd58});
        v.push_back({mk(7'b0010011, 3'b101, 1'b1), 32'hF0000000, 32'd4,
                     {4'h7, 3'b000, 2'b01, 6'b001010}, 32'hFF000000});
        v.push_back({mk(7'b0010011, 3'b001, 1'b0), 32'd1, 32'd31,
                     {4'h5, 3'b000, 2'b01, 6'b001010}, 32'h80000000});
        v.push_back({mk(7'b1111111, 3'b111, 1'b1), 32'd3, 32'd4,
                     15'd0, 32'd7});
        foreach (v[k]) begin
            drive(v[k].i, v[k].a, v[k].b, v[k].r);
            #1;
            checks++;
            if (ctl_now() !== v[k].c) begin
                errors++;
                $display("FAIL dec_ctl[%0d]: got %h want %h", k, ctl_now(), v[k].c);
            end
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL dec_res[%0d]: scoreboard empty", k);
            end else begin
                exp_t e = sb.pop_front();
                if ({result, zero, Sign} !== {e.r, e.z, e.s}) begin
                    errors++;
                    $display("FAIL dec_res[%0d]: got r=%h z=%b s=%b want r=%h z=%b s=%b",
                             k, result, zero, Sign, e.r, e.z, e.s);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom();
            rb = $urandom();
            if (k[0])
                drive(32'h402180B3, ra, rb, ra - rb);
            else
                drive(32'h003100B3, ra, rb, ra + rb);
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b[%0d]: scoreboard empty", k);
            end else begin
                exp_t e = sb.pop_front();
                if ({result, zero, Sign} !== {e.r, e.z, e.s}) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got r=%h z=%b s=%b want r=%h z=%b s=%b",
                             k, result, zero, Sign, e.r, e.z, e.s);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        instr = 32'h003100B3;
        a     = 32'h80000005;
        b     = 32'd5;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({result, zero, Sign} !== {32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_rst: got r=%h z=%b s=%b want 0/0/0",
                     result, zero, Sign);
        end
        rst_n = 1'b1;
        drive(32'h003100B3, 32'h80000005, 32'd5, 32'h8000000A);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL mid_release: scoreboard empty");
        end else begin
            exp_t e = sb.pop_front();
            if ({result, zero, Sign} !== {e.r, e.z, e.s}) begin
                errors++;
                $display("FAIL mid_release: got r=%h z=%b s=%b want r=%h z=%b s=%b",
                         result, zero, Sign, e.r, e.z, e.s);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instr = '0;
        a     = '0;
        b     = '0;
        test_reset();
        test_alu();
        test_decode();
        test_back_to_back();
        test_reset_midstream();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
